srl_delay_arbiter: RTL
======================

Name: srl_delay_arbiter

Overview:
- Round-robin arbiter and pipeline controller that shares one SRL_bus delay line (depth C_CLOCK_CYCLES, width C_DATA_WIDTH) among C_NUM_REQ requesters.
- Drives the delay line's ce and an input-mux select.
- Tracks a valid bit and requester tag alongside the data, so each beat leaves the delay line qualified and tagged exactly C_CLOCK_CYCLES advances after acceptance.
- Applies downstream backpressure by freezing ce.

Parameters:
- C_CLOCK_CYCLES, 4, delay-line depth; must match the driven SRL_bus; legal range 1..64 (0 not supported).
- C_NUM_REQ, 4, number of requesters; legal range 2..16.
- C_TAG_WIDTH, 2, width of the tag/select; must be >= clog2(C_NUM_REQ).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; asynchronous assert, active-low; clears all state.
- req_valid  input  C_NUM_REQ  per-requester beat available.
- req_ready  output  C_NUM_REQ  one-hot; the beat of requester i is accepted this cycle.
- flush  input  1  synchronous; discards all in-flight beats.
- srl_ce  output  1  clock enable to the SRL_bus.
- srl_sel  output  C_TAG_WIDTH  index of the requester whose data must be muxed onto SRL_bus data_in this cycle.
- out_valid  output  1  beat at SRL_bus data_out is valid.
- out_tag  output  C_TAG_WIDTH  requester index of the output beat.
- out_ready  input  1  downstream consumes the output beat.
- occupancy  output  7  number of valid beats in flight, 0..C_CLOCK_CYCLES.

Behaviour:
- State:
  - vld_sr: C_CLOCK_CYCLES bits.
  - tag_sr: C_CLOCK_CYCLES x C_TAG_WIDTH.
  - rr_ptr: C_TAG_WIDTH.
  - occ: count register.
- Reset (rst=0, async):
  - vld_sr=0, tag_sr=0, rr_ptr=0, occ=0.
  - Outputs: out_valid=0, out_tag=0, occupancy=0, req_ready=0, srl_sel=0, srl_ce=1.
- Advance:
  - srl_ce = ~(vld_sr[C_CLOCK_CYCLES-1] & ~out_ready). The line advances when the head is empty or is being consumed.
  - srl_ce is combinational.
  - When flush=1, srl_ce=1.
- Arbitration (combinational):
  - Scan requesters in order rr_ptr, rr_ptr+1, ... wrapping modulo C_NUM_REQ.
  - The first requester with req_valid=1 is the grant g.
  - srl_sel = g, or rr_ptr if there is no request.
  - req_ready[g] = srl_ce & ~flush & req_valid[g]; all other bits are 0.
  - req_ready depends combinationally on req_valid and out_ready; requesters must not make req_valid depend on req_ready.
- Accept: on a rising edge with srl_ce=1 and no flush:
  - vld_sr shifts in (any req_ready), tag_sr shifts in g.
  - On an accept, rr_ptr becomes (g+1) mod C_NUM_REQ.
  - With no accept, rr_ptr holds and a bubble (valid 0) shifts in.
- srl_ce=0: vld_sr, tag_sr and rr_ptr hold, which matches the frozen SRL_bus.
- Output:
  - out_valid = vld_sr[C_CLOCK_CYCLES-1]; out_tag = tag_sr[C_CLOCK_CYCLES-1].
  - Both are aligned with SRL_bus data_out.
- Latency:
  - A beat accepted at edge k appears at out_valid after C_CLOCK_CYCLES advancing edges.
  - With no stalls this is C_CLOCK_CYCLES cycles.
  - C_CLOCK_CYCLES=1 degenerates correctly: a one-stage line with a full-throughput skid-free handshake.
- Throughput: one beat per cycle while out_ready=1.
- Occupancy:
  - occ increments on accept without output consume.
  - occ decrements on consume (out_valid & out_ready & srl_ce) without accept.
  - occ holds when accept and consume happen together.
  - occ never exceeds C_CLOCK_CYCLES.
- Flush:
  - On the next edge, vld_sr=0 and occ=0.
  - tag_sr and rr_ptr are unchanged.
  - No accept occurs that cycle (flush beats req_valid).
  - out_valid in the flush cycle still reflects the pre-flush head. A consume in that cycle counts as a transfer to downstream.
  - SRL_bus data contents are not cleared; vld_sr qualifies them.
- Reset mid-operation: all in-flight beats are lost and the state matches post-reset.
  - The SRL_bus keeps its own reset; its stale data is masked because vld_sr=0.
- Fairness: a continuously asserting requester waits at most C_NUM_REQ-1 accepts.

Test Plan:
- Reset, C_CLOCK_CYCLES=4, only req_valid[2]=1, out_ready=1 -> req_ready=0100 every cycle; out_valid first rises 4 cycles after the first accept; out_tag=2; occupancy settles at 4.
- All four requesters valid continuously, out_ready=1 -> grant order 0,1,2,3,0,...; out_tag sequence matches 4 cycles later; one beat per cycle.
- Line full (occupancy=4), out_ready=0 for 3 cycles -> srl_ce=0 and req_ready=0 for those cycles; out_valid/out_tag held; rr_ptr unchanged; after release, order continues without loss or duplication.
- Sparse traffic, req_valid[1] pulsed every 3rd cycle -> bubbles between beats; out_valid pattern 100100... delayed by 4; occupancy toggles between 1 and 2.
- flush asserted with 3 beats in flight and req_valid[0]=1 -> req_ready=0 in the flush cycle; next cycle occupancy=0 and out_valid=0; no flushed tag ever emerges.
- rst pulsed low asynchronously between edges with a full line -> out_valid, occupancy and req_ready drop to 0 immediately; the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/srl_delay_arbiter.sv
// Round-robin arbiter and pipeline controller for a shared SRL delay line.
// Carries a valid bit and a requester tag alongside the data, and stalls the line on backpressure.
module srl_delay_arbiter #(
    parameter int unsigned C_CLOCK_CYCLES = 4,
    parameter int unsigned C_NUM_REQ      = 4,
    parameter int unsigned C_TAG_WIDTH    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [C_NUM_REQ-1:0]   req_valid,
    output logic [C_NUM_REQ-1:0]   req_ready,
    input  logic                   flush,
    output logic                   srl_ce,
    output logic [C_TAG_WIDTH-1:0] srl_sel,
    output logic                   out_valid,
    output logic [C_TAG_WIDTH-1:0] out_tag,
    input  logic                   out_ready,
    output logic [6:0]             occupancy
);

    localparam int unsigned HEAD = C_CLOCK_CYCLES - 1;
    localparam logic [C_TAG_WIDTH-1:0] LAST_REQ = C_TAG_WIDTH'(C_NUM_REQ - 1);

    logic [C_CLOCK_CYCLES-1:0]                  vld_sr_q, vld_sr_d;
    logic [C_CLOCK_CYCLES-1:0][C_TAG_WIDTH-1:0] tag_sr_q, tag_sr_d;
    logic [C_TAG_WIDTH-1:0]                     rr_ptr_q, rr_ptr_d;
    logic [6:0]                                 occ_q, occ_d;

    logic                   found_hi, found_lo;
    logic [C_TAG_WIDTH-1:0] grant_hi, grant_lo;
    logic                   grant_any;
    logic [C_TAG_WIDTH-1:0] grant;
    logic [C_TAG_WIDTH-1:0] sel_int;
    logic                   head_valid;
    logic                   accept;
    logic                   consume;

    // Two-segment priority scan: the lowest requester at or above rr_ptr wins, and
    // otherwise the lowest requester below it, which equals the wrapping scan order.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        grant_hi = '0;
        grant_lo = '0;
        for (int j = C_NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                if (j >= int'(rr_ptr_q)) begin
                    found_hi = 1'b1;
                    grant_hi = C_TAG_WIDTH'(j);
                end else begin
                    found_lo = 1'b1;
                    grant_lo = C_TAG_WIDTH'(j);
                end
            end
        end
        grant_any = found_hi | found_lo;
        grant     = found_hi ? grant_hi : grant_lo;
        sel_int   = grant_any ? grant : rr_ptr_q;
    end

    always_comb begin
        head_valid = vld_sr_q[HEAD];
        srl_ce     = flush | ~(head_valid & ~out_ready);
        accept     = srl_ce & ~flush & grant_any;
        consume    = head_valid & out_ready & srl_ce;
        // Gating with rst keeps the handshake quiet while reset is held low.
        for (int j = 0; j < C_NUM_REQ; j++) begin
            req_ready[j] = rst & accept & (grant == C_TAG_WIDTH'(j));
        end
        srl_sel = rst ? sel_int : '0;
    end

    always_comb begin
        vld_sr_d = vld_sr_q;
        tag_sr_d = tag_sr_q;
        rr_ptr_d = rr_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            // Tags and pointer are left alone; the cleared valid bits mask the stale data.
            vld_sr_d = '0;
            occ_d    = '0;
        end else if (srl_ce) begin
            for (int i = C_CLOCK_CYCLES - 1; i > 0; i--) begin
                vld_sr_d[i] = vld_sr_q[i-1];
                tag_sr_d[i] = tag_sr_q[i-1];
            end
            vld_sr_d[0] = accept;
            tag_sr_d[0] = sel_int;
            if (accept) begin
                rr_ptr_d = (grant == LAST_REQ) ? '0 : grant + 1'b1;
            end
            if (accept && !consume) begin
                occ_d = occ_q + 7'd1;
            end else if (consume && !accept) begin
                occ_d = occ_q - 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_sr_q <= '0;
            tag_sr_q <= '0;
            rr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            vld_sr_q <= vld_sr_d;
            tag_sr_q <= tag_sr_d;
            rr_ptr_q <= rr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign out_valid = vld_sr_q[HEAD];
    assign out_tag   = tag_sr_q[HEAD];
    assign occupancy = occ_q;

endmodule
